snoop_bus_arbiter: RTL and testbench

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

---
 rtl/snoop_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter
// Round-robin arbiter for a shared snooping bus. The arbiter picks one CPU per
// transaction, broadcasts that CPU's line address for one snoop cycle, and then
// sources the data either from a peer cache that reported a hit or from unified
// memory. Invalidates (and write misses) strobe inv_out to every non-owner CPU.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   req_rd_miss/wr_miss/inv    per-CPU level requests
//   req_addr                   per-CPU line address, CPU i at [i*TAG_W +: TAG_W]
//   snoop_found                per-CPU snoop hit, only looked at in SNOOP
//   mem_rdy                    memory read done pulse, only looked at in MEM
//   grant                      one-hot bus owner, zero when idle
//   snoop_valid, snoop_addr    snoop broadcast
//   inv_out                    invalidate strobe to non-owners
//   datasel, peer_sel          data source (00 none, 01 memory, 10 peer) and peer index
//   mem_re, mem_addr           memory read request
//   done                       one-hot completion pulse to the owner
//
// state | meaning
// IDLE  | bus free, arbitrate among pending requests
// SNOOP | broadcast owner address, sample snoop_found
// MEM   | waiting on unified memory read
// DONE  | completion pulse to owner, update round-robin pointer
module snoop_bus_arbiter #(
  parameter int NUM_CPU = 4,
  parameter int TAG_W   = 11,
  parameter int IW      = $clog2(NUM_CPU)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CPU-1:0]       req_rd_miss,
  input  logic [NUM_CPU-1:0]       req_wr_miss,
  input  logic [NUM_CPU-1:0]       req_inv,
  input  logic [NUM_CPU*TAG_W-1:0] req_addr,
  input  logic [NUM_CPU-1:0]       snoop_found,
  input  logic                     mem_rdy,
  output logic [NUM_CPU-1:0]       grant,
  output logic                     snoop_valid,
  output logic [TAG_W-1:0]         snoop_addr,
  output logic [NUM_CPU-1:0]       inv_out,
  output logic [1:0]               datasel,
  output logic [IW-1:0]            peer_sel,
  output logic                     mem_re,
  output logic [TAG_W-1:0]         mem_addr,
  output logic [NUM_CPU-1:0]       done
);

  typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_MEM, S_DONE} state_t;
  typedef enum logic [1:0] {T_RD, T_WR, T_INV} txn_t;

  localparam logic [NUM_CPU-1:0] ONE_HOT0 = NUM_CPU'(1);

  state_t             state;
  txn_t               txn;
  logic [IW-1:0]      last_owner;
  logic [IW-1:0]      owner_idx;

  logic [NUM_CPU-1:0] any_req;
  logic               hi_valid, lo_valid;
  logic [IW-1:0]      hi_idx, lo_idx, pick_idx;
  logic [TAG_W-1:0]   pick_addr;
  logic               pick_inv, pick_wr;
  logic [NUM_CPU-1:0] found_m;
  logic [IW-1:0]      peer_idx;

  assign any_req = req_rd_miss | req_wr_miss | req_inv;

  // Round robin without a rotator: lowest requester above last_owner wins,
  // otherwise wrap around to the lowest requester overall.
  always_comb begin
    hi_valid = 1'b0;
    hi_idx   = '0;
    lo_valid = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_CPU - 1; i >= 0; i--) begin
      if (any_req[i]) begin
        lo_valid = 1'b1;
        lo_idx   = IW'(i);
        if (IW'(i) > last_owner) begin
          hi_valid = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
    pick_idx = hi_valid ? hi_idx : lo_idx;
  end

  always_comb begin
    pick_addr = '0;
    pick_inv  = 1'b0;
    pick_wr   = 1'b0;
    for (int i = 0; i < NUM_CPU; i++) begin
      if (IW'(i) == pick_idx) begin
        pick_addr = req_addr[i*TAG_W +: TAG_W];
        pick_inv  = req_inv[i];
        pick_wr   = req_wr_miss[i];
      end
    end
  end

  // The owner always hits its own snoop, so its bit never counts as a peer.
  assign found_m = snoop_found & ~grant;

  always_comb begin
    peer_idx = '0;
    for (int i = NUM_CPU - 1; i >= 0; i--) begin
      if (found_m[i]) peer_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      txn         <= T_RD;
      last_owner  <= IW'(NUM_CPU - 1);
      owner_idx   <= '0;
      grant       <= '0;
      snoop_valid <= 1'b0;
      snoop_addr  <= '0;
      inv_out     <= '0;
      datasel     <= 2'b00;
      peer_sel    <= '0;
      mem_re      <= 1'b0;
      mem_addr    <= '0;
      done        <= '0;
    end else begin
      done    <= '0;
      inv_out <= '0;
      case (state)
        S_IDLE: begin
          if (lo_valid) begin
            grant       <= ONE_HOT0 << pick_idx;
            owner_idx   <= pick_idx;
            txn         <= pick_inv ? T_INV : (pick_wr ? T_WR : T_RD);
            snoop_valid <= 1'b1;
            snoop_addr  <= pick_addr;
            state       <= S_SNOOP;
          end
        end
        S_SNOOP: begin
          snoop_valid <= 1'b0;
          if (txn == T_INV) begin
            inv_out <= ~grant;
            datasel <= 2'b00;
            done    <= grant;
            state   <= S_DONE;
          end else if (|found_m) begin
            datasel  <= 2'b10;
            peer_sel <= peer_idx;
            done     <= grant;
            if (txn == T_WR) inv_out <= ~grant;
            state    <= S_DONE;
          end else begin
            mem_re   <= 1'b1;
            mem_addr <= snoop_addr;
            datasel  <= 2'b01;
            if (txn == T_WR) inv_out <= ~grant;
            state    <= S_MEM;
          end
        end
        S_MEM: begin
          if (mem_rdy) begin
            mem_re <= 1'b0;
            done   <= grant;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          grant      <= '0;
          datasel    <= 2'b00;
          peer_sel   <= '0;
          last_owner <= owner_idx;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
module tb_snoop_bus_arbiter;

  localparam int NUM_CPU = 4;
  localparam int TAG_W   = 11;
  localparam int IW      = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CPU-1:0]       req_rd_miss, req_wr_miss, req_inv, snoop_found;
  logic [NUM_CPU*TAG_W-1:0] req_addr;
  logic                     mem_rdy;
  logic [NUM_CPU-1:0]       grant, inv_out, done;
  logic                     snoop_valid, mem_re;
  logic [TAG_W-1:0]         snoop_addr, mem_addr;
  logic [1:0]               datasel;
  logic [IW-1:0]            peer_sel;

  int n_checks = 0;
  int n_errors = 0;

  logic               mon_en = 1'b0;
  logic [NUM_CPU-1:0] prev_grant = '0;
  int                 outstanding = 0;
  int                 n_grants = 0;

  snoop_bus_arbiter #(.NUM_CPU(NUM_CPU), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_rd_miss(req_rd_miss), .req_wr_miss(req_wr_miss), .req_inv(req_inv),
    .req_addr(req_addr), .snoop_found(snoop_found), .mem_rdy(mem_rdy),
    .grant(grant), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .inv_out(inv_out), .datasel(datasel), .peer_sel(peer_sel),
    .mem_re(mem_re), .mem_addr(mem_addr), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus protocol monitor for the random phase.
  always @(negedge clk) begin
    if (mon_en) begin
      check("grant_onehot0", 32'($onehot0(grant)), 1);
      check("inv_excludes_owner", 32'(inv_out & grant), 0);
      if (grant != '0 && prev_grant == '0) begin
        check("grant_without_pending_done", outstanding, 0);
        outstanding = 1;
        n_grants++;
      end
      if (done != '0) begin
        check("done_matches_owner", 32'(done), 32'(grant));
        check("done_once_per_grant", outstanding, 1);
        outstanding = 0;
      end
      prev_grant = grant;
    end
  end

  initial begin
    rst_n = 1'b0;
    req_rd_miss = '0; req_wr_miss = '0; req_inv = '0;
    req_addr = '0; snoop_found = '0; mem_rdy = 1'b0;

    // reset values
    #12;
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_inv_out", 32'(inv_out), 0);
    check("rst_snoop_valid", 32'(snoop_valid), 0);
    check("rst_mem_re", 32'(mem_re), 0);
    check("rst_datasel", 32'(datasel), 0);
    check("rst_peer_sel", 32'(peer_sel), 0);
    check("rst_snoop_addr", 32'(snoop_addr), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    rst_n = 1'b1;
    tick();

    // all CPUs hold a read miss; a peer always hits
    req_rd_miss = 4'b1111;
    snoop_found = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("rr_grant", 32'(grant), 32'(1 << (n % 4)));
      check("rr_snoop_valid", 32'(snoop_valid), 1);
      tick();
      check("rr_done", 32'(done), 32'(1 << (n % 4)));
      check("rr_datasel", 32'(datasel), 2);
      check("rr_peer_sel", 32'(peer_sel), (n % 4 == 0) ? 1 : 0);
      tick();
      check("rr_idle_gap", 32'(grant), 0);
      check("rr_idle_done", 32'(done), 0);
    end
    req_rd_miss = '0;
    snoop_found = '0;
    tick();

    // CPU2 read miss served by the lowest peer hit
    req_rd_miss = 4'b0100;
    req_addr[2*TAG_W +: TAG_W] = 11'h155;
    snoop_found = 4'b1010;
    tick();
    check("peer_grant", 32'(grant), 4);
    check("peer_snoop_valid", 32'(snoop_valid), 1);
    check("peer_snoop_addr", 32'(snoop_addr), 'h155);
    req_rd_miss = '0;  // dropping the request must not abort
    tick();
    check("peer_done", 32'(done), 4);
    check("peer_datasel", 32'(datasel), 2);
    check("peer_sel", 32'(peer_sel), 1);
    check("peer_no_inv", 32'(inv_out), 0);
    check("peer_no_mem_re", 32'(mem_re), 0);
    check("peer_snoop_valid_off", 32'(snoop_valid), 0);
    tick();
    check("peer_idle_grant", 32'(grant), 0);
    check("peer_idle_datasel", 32'(datasel), 0);

    // CPU1 write miss, only the owner hits -> memory, with invalidate
    req_wr_miss = 4'b0010;
    req_addr[1*TAG_W +: TAG_W] = 11'h2ab;
    snoop_found = 4'b0010;
    tick();
    check("wr_grant", 32'(grant), 2);
    req_wr_miss = '0;
    mem_rdy = 1'b1;  // outside MEM, must be ignored
    tick();
    mem_rdy = 1'b0;
    snoop_found = '0;
    check("wr_mem_re", 32'(mem_re), 1);
    check("wr_mem_addr", 32'(mem_addr), 'h2ab);
    check("wr_datasel", 32'(datasel), 1);
    check("wr_inv_out", 32'(inv_out), 'b1101);
    check("wr_no_early_done", 32'(done), 0);
    tick();
    check("wr_inv_one_cycle", 32'(inv_out), 0);
    check("wr_mem_re_hold", 32'(mem_re), 1);
    tick();
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    check("wr_done", 32'(done), 2);
    check("wr_mem_re_drop", 32'(mem_re), 0);
    check("wr_done_datasel", 32'(datasel), 1);
    tick();
    check("wr_idle_done", 32'(done), 0);

    // CPU3 inv + rd_miss together, CPU0 also waiting; last owner is CPU1
    req_inv = 4'b1000;
    req_rd_miss = 4'b1001;
    snoop_found = 4'b0001;
    tick();
    check("inv_grant_rr", 32'(grant), 8);
    req_inv = '0;
    req_rd_miss = 4'b0001;
    tick();
    check("inv_inv_out", 32'(inv_out), 'b0111);
    check("inv_done", 32'(done), 8);
    check("inv_no_mem_re", 32'(mem_re), 0);
    check("inv_datasel", 32'(datasel), 0);
    tick();
    check("inv_idle_gap", 32'(grant), 0);
    snoop_found = 4'b0010;
    tick();
    check("cpu0_grant", 32'(grant), 1);
    req_rd_miss = '0;
    tick();
    check("cpu0_done", 32'(done), 1);
    check("cpu0_peer_sel", 32'(peer_sel), 1);
    tick();

    // reset while in MEM; last owner is CPU0 before the reset
    req_rd_miss = 4'b0010;
    snoop_found = '0;
    tick();
    check("rstmem_grant", 32'(grant), 2);
    tick();
    check("rstmem_mem_re", 32'(mem_re), 1);
    req_rd_miss = 4'b0011;
    #3;
    rst_n = 1'b0;
    #1;
    check("rstmem_mem_re_async", 32'(mem_re), 0);
    check("rstmem_grant_async", 32'(grant), 0);
    check("rstmem_no_done", 32'(done), 0);
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    check("rstmem_cpu0_first", 32'(grant), 1);
    req_rd_miss = '0;
    snoop_found = 4'b0100;
    tick();
    check("rstmem_cpu0_done", 32'(done), 1);
    tick();
    snoop_found = '0;

    // random stimulus under the protocol monitor
    mon_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      req_rd_miss = 4'($urandom) & 4'($urandom);
      req_wr_miss = 4'($urandom) & 4'($urandom) & 4'($urandom);
      req_inv     = 4'($urandom) & 4'($urandom) & 4'($urandom);
      req_addr    = 44'({$urandom, $urandom});
      snoop_found = 4'($urandom);
      mem_rdy     = ($urandom_range(0, 2) == 0);
      tick();
    end
    req_rd_miss = '0; req_wr_miss = '0; req_inv = '0; snoop_found = '0;
    mem_rdy = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    mem_rdy = 1'b0;
    mon_en = 1'b0;
    check("rand_drained", outstanding, 0);
    check("rand_bus_idle", 32'(grant), 0);
    check("rand_enough_grants", 32'(n_grants > 50), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
